// File: rtl/game_timer.sv
// Game-period MM:SS countdown driven by a divided-clock tick tap, with BCD digit outputs.
// Optional expiry buzzer is built only when GAME_TIMER_BUZZER_EN is defined.
module game_timer #(
  parameter int START_MIN  = 10,
  parameter int START_SEC  = 0,
  parameter int BUZZ_TICKS = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_pause,
  input  logic       reload,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  localparam logic [15:0] START_BCD = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                       4'(START_SEC / 10), 4'(START_SEC % 10)};

  // One-second BCD decrement with borrow chain; saturates at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (d == 16'h0000) return d;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  state_t      state;
  logic [15:0] digits;
  logic [15:0] next_dig;
  logic        tick_d;
  logic        tick_rise;
  logic        expire_now;

  assign tick_rise  = tick_in & ~tick_d;
  assign next_dig   = bcd_dec(digits);
  assign expire_now = (state == RUNNING) && !start_pause && tick_rise && (next_dig == 16'h0000);
  assign {min_tens, min_ones, sec_tens, sec_ones} = digits;

  // Priority: reload > start_pause > tick_rise.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_d  <= 1'b0;
      state   <= IDLE;
      digits  <= START_BCD;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick_d  <= tick_in;
      expired <= 1'b0;
      if (reload) begin
        digits  <= START_BCD;
        state   <= IDLE;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_pause && digits != 16'h0000) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            if (start_pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick_rise) begin
              digits <= next_dig;
              if (expire_now) begin
                state   <= EXPIRED;
                running <= 1'b0;
                expired <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (start_pause) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_TIMER_BUZZER_EN
  logic [3:0] buzz_cnt;

  // Buzzer counts tick rises after expiry and drops on the BUZZ_TICKS-th one.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      buzzer   <= 1'b0;
      buzz_cnt <= 4'd0;
    end else if (reload) begin
      buzzer   <= 1'b0;
      buzz_cnt <= 4'd0;
    end else if (expire_now) begin
      buzzer   <= 1'b1;
      buzz_cnt <= 4'd0;
    end else if (buzzer && tick_rise) begin
      if (buzz_cnt == 4'(BUZZ_TICKS - 1)) buzzer <= 1'b0;
      buzz_cnt <= buzz_cnt + 4'd1;
    end
  end
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (10:00 and 00:03) share stimulus and are checked
// every cycle against a seconds-based model, plus literal checkpoints.
module tb_game_timer;

  logic clock_in = 1'b0;
  always #10 clock_in = ~clock_in;

  logic reset_n, tick_in, start_pause, reload;
  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic a_run, a_exp, a_buzz, b_run, b_exp, b_buzz;

  int checks = 0;
  int errors = 0;
  int b_exp_cycles = 0;

`ifdef GAME_TIMER_BUZZER_EN
  localparam bit BUZZ_ON = 1'b1;
`else
  localparam bit BUZZ_ON = 1'b0;
`endif
  localparam int BUZZ_N = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  game_timer #(.START_MIN(10), .START_SEC(0), .BUZZ_TICKS(BUZZ_N)) dut_a (
    .clock_in(clock_in), .reset_n(reset_n), .tick_in(tick_in),
    .start_pause(start_pause), .reload(reload),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .running(a_run), .expired(a_exp), .buzzer(a_buzz));

  game_timer #(.START_MIN(0), .START_SEC(3), .BUZZ_TICKS(BUZZ_N)) dut_b (
    .clock_in(clock_in), .reset_n(reset_n), .tick_in(tick_in),
    .start_pause(start_pause), .reload(reload),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .running(b_run), .expired(b_exp), .buzzer(b_buzz));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int r);
    int mm, ss;
    mm = r / 60;
    ss = r % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Model: remaining time as plain seconds per instance
  int s0[2] = '{600, 3};
  int rem[2], mode[2], bcnt[2];
  bit m_exp[2], m_buzz[2];
  bit prev_tick;

  always @(posedge clock_in) begin
    bit rise;
    rise = 1'b0;
    if (!reset_n) begin
      prev_tick = 1'b0;
      for (int i = 0; i < 2; i++) begin
        rem[i] = s0[i]; mode[i] = M_IDLE; m_exp[i] = 1'b0; m_buzz[i] = 1'b0; bcnt[i] = 0;
      end
    end else begin
      rise = tick_in && !prev_tick;
      prev_tick = tick_in;
      for (int i = 0; i < 2; i++) begin
        m_exp[i] = 1'b0;
        if (reload) begin
          rem[i] = s0[i]; mode[i] = M_IDLE; m_buzz[i] = 1'b0;
        end else begin
          if (m_buzz[i] && rise) begin
            bcnt[i]++;
            if (bcnt[i] == BUZZ_N) m_buzz[i] = 1'b0;
          end
          if (start_pause) begin
            if (mode[i] == M_IDLE && rem[i] != 0) mode[i] = M_RUN;
            else if (mode[i] == M_RUN) mode[i] = M_PAUSE;
            else if (mode[i] == M_PAUSE) mode[i] = M_RUN;
          end else if (rise && mode[i] == M_RUN) begin
            rem[i]--;
            if (rem[i] == 0) begin
              mode[i] = M_EXP; m_exp[i] = 1'b1; m_buzz[i] = BUZZ_ON; bcnt[i] = 0;
            end
          end
        end
      end
    end
    #1;
    chk("a_digits", {a_mt, a_mo, a_st, a_so}, to_bcd(rem[0]));
    chk("a_running", a_run, mode[0] == M_RUN);
    chk("a_expired", a_exp, m_exp[0]);
    chk("a_buzzer", a_buzz, m_buzz[0]);
    chk("b_digits", {b_mt, b_mo, b_st, b_so}, to_bcd(rem[1]));
    chk("b_running", b_run, mode[1] == M_RUN);
    chk("b_expired", b_exp, m_exp[1]);
    chk("b_buzzer", b_buzz, m_buzz[1]);
    if (b_exp) b_exp_cycles++;
  end

  task automatic cyc(input logic t, input logic sp, input logic rl);
    @(negedge clock_in);
    tick_in = t; start_pause = sp; reload = rl;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; tick_in = 1'b0; start_pause = 1'b0; reload = 1'b0;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    chk("lit_rst_a_digits", {a_mt, a_mo, a_st, a_so}, 16'h1000);
    chk("lit_rst_a_flags", {a_run, a_exp, a_buzz}, 16'h0);
    chk("lit_rst_b_digits", {b_mt, b_mo, b_st, b_so}, 16'h0003);

    ticks(5);
    chk("lit_idle_ticks", {a_mt, a_mo, a_st, a_so}, 16'h1000);

    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_start_running", a_run, 1'b1);

    ticks(3);
    chk("lit_b_expired_digits", {b_mt, b_mo, b_st, b_so}, 16'h0000);
    chk("lit_b_expired_seen", b_exp_cycles, 16'd1);
    chk("lit_a_0957", {a_mt, a_mo, a_st, a_so}, 16'h0957);

    ticks(58);
    chk("lit_a_0859", {a_mt, a_mo, a_st, a_so}, 16'h0859);
    chk("lit_b_expired_once", b_exp_cycles, 16'd1);
    chk("lit_b_still_zero", {b_mt, b_mo, b_st, b_so}, 16'h0000);

    ticks(494);
    chk("lit_a_0045", {a_mt, a_mo, a_st, a_so}, 16'h0045);

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_pause_digits", {a_mt, a_mo, a_st, a_so}, 16'h0045);
    chk("lit_pause_running", a_run, 1'b0);
    chk("lit_b_ignores_sp", {b_mt, b_mo, b_st, b_so, 3'b0, b_run}, 16'h0000);
    ticks(4);
    chk("lit_paused_ticks", {a_mt, a_mo, a_st, a_so}, 16'h0045);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_resume_running", a_run, 1'b1);
    ticks(1);
    chk("lit_a_0044", {a_mt, a_mo, a_st, a_so}, 16'h0044);

    repeat (100) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_held_tick", {a_mt, a_mo, a_st, a_so}, 16'h0043);

    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_reload_a", {a_mt, a_mo, a_st, a_so}, 16'h1000);
    chk("lit_reload_a_run", a_run, 1'b0);
    chk("lit_reload_b", {b_mt, b_mo, b_st, b_so}, 16'h0003);

    // Buzzer: expiry, then BUZZ_N tick rises
    cyc(1'b0, 1'b1, 1'b0);
    ticks(3);
    chk("lit_buzz_on", b_buzz, BUZZ_ON);
    ticks(2);
    chk("lit_buzz_hold", b_buzz, BUZZ_ON);
    ticks(1);
    chk("lit_buzz_off", b_buzz, 1'b0);

    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(3);
    ticks(1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_buzz_reload", b_buzz, 1'b0);

    // Asynchronous reset in the middle of a cycle
    cyc(1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("lit_a_0958", {a_mt, a_mo, a_st, a_so}, 16'h0958);
    @(posedge clock_in);
    #5 reset_n = 1'b0;
    #1;
    chk("lit_async_rst_digits", {a_mt, a_mo, a_st, a_so}, 16'h1000);
    chk("lit_async_rst_run", a_run, 1'b0);
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
